// File: rtl/vga_window_addr_gen.sv
// Purpose: maps VGA raster counters to frame-buffer addresses for a movable image window (build with VGA_SCALE2X_EN for 2x pixel doubling).
// Latency: 2 pix_en cycles from hcnt/vcnt to video_address/in_window.
// Backpressure: none; pix_en low freezes the pipeline, while pos_load is captured on every clk edge.
//
// Ports:
//   clk, rst_n           pixel clock, async active-low reset
//   pix_en               pixel tick, the pipeline advances only when high
//   hcnt, vcnt           raster position of the current pixel
//   img_sel              requested image index (held in shadow until frame start)
//   pos_x, pos_y         requested window top-left corner (held in shadow until frame start)
//   pos_load             strobe capturing pos_x/pos_y/img_sel into the shadow registers
//   video_address        registered frame-buffer address, BLACK_ADDR outside the window
//   in_window            registered flag aligned with video_address
module vga_window_addr_gen #(
  parameter int                ADDR_W     = 32,
  parameter int                IMG_W      = 250,
  parameter int                IMG_H      = 250,
  parameter int                NUM_IMG    = 2,
  parameter logic [ADDR_W-1:0] IMG_STRIDE = ADDR_W'(32'h10000),
  parameter logic [ADDR_W-1:0] BLACK_ADDR = ADDR_W'(32'hFFFF),
  parameter logic [9:0]        X0         = 10'd150,
  parameter logic [9:0]        Y0         = 10'd80,
  localparam int               SEL_W      = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_en,
  input  logic [9:0]        hcnt,
  input  logic [9:0]        vcnt,
  input  logic [SEL_W-1:0]  img_sel,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              pos_load,
  output logic [ADDR_W-1:0] video_address,
  output logic              in_window
);

`ifdef VGA_SCALE2X_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif

  logic [9:0]        sh_x, sh_y, act_x, act_y;
  logic [SEL_W-1:0]  sh_sel;
  logic              frame_vld;
  logic [ADDR_W-1:0] row_base;
  logic [10:0]       col_cnt;
  logic              s1_in_win;
  logic [ADDR_W-1:0] s1_addr;

  logic              frame_start, in_win, col_start, last_px, col_step, row_step;
  logic [9:0]        new_x, new_y, eff_x, eff_y;
  logic [SEL_W-1:0]  new_sel, sel_cl;
  logic [ADDR_W-1:0] new_off, eff_row;
  logic [10:0]       x_end, y_end, col_eff;

  // At frame start the incoming values (shadow, or the coinciding load) apply
  // to the frame-start pixel itself, so the whole frame sees one window.
  assign frame_start = pix_en && (hcnt == 10'd0) && (vcnt == 10'd0);
  assign new_x   = pos_load ? pos_x   : sh_x;
  assign new_y   = pos_load ? pos_y   : sh_y;
  assign new_sel = pos_load ? img_sel : sh_sel;
  assign sel_cl  = (32'(new_sel) >= 32'(NUM_IMG)) ? '0 : new_sel;
  // Image offset is only consumed at frame start to seed row_base.
  assign new_off = IMG_STRIDE * ADDR_W'(sel_cl);
  assign eff_x   = frame_start ? new_x   : act_x;
  assign eff_y   = frame_start ? new_y   : act_y;
  assign eff_row = frame_start ? new_off : row_base;

  // 11-bit edges: a window running past 1023 is clipped, never wrapped.
  assign x_end  = {1'b0, eff_x} + 11'(IMG_W * S);
  assign y_end  = {1'b0, eff_y} + 11'(IMG_H * S);
  assign in_win = (frame_start || frame_vld) &&
                  ({1'b0, hcnt} >= {1'b0, eff_x}) && ({1'b0, hcnt} < x_end) &&
                  ({1'b0, vcnt} >= {1'b0, eff_y}) && ({1'b0, vcnt} < y_end);
  assign col_start = (hcnt == eff_x);
  assign col_eff   = col_start ? 11'd0 : col_cnt;
  // A clipped line ends at hcnt=1023, which still has to advance the row.
  assign last_px = in_win && ((({1'b0, hcnt} + 11'd1) == x_end) || (hcnt == 10'h3FF));

`ifdef VGA_SCALE2X_EN
  // Phase bits: column/row advance on every second in-window pixel/line.
  logic x_ph, y_ph, x_ph_eff, y_ph_eff;
  assign x_ph_eff = col_start   ? 1'b0 : x_ph;
  assign y_ph_eff = frame_start ? 1'b0 : y_ph;
  assign col_step = x_ph_eff;
  assign row_step = y_ph_eff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_ph <= 1'b0;
      y_ph <= 1'b0;
    end else if (pix_en) begin
      if (in_win) x_ph <= ~x_ph_eff;
      if (last_px) y_ph <= ~y_ph_eff;
      else if (frame_start) y_ph <= 1'b0;
    end
  end
`else
  assign col_step = 1'b1;
  assign row_step = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_x   <= X0;
      sh_y   <= Y0;
      sh_sel <= '0;
    end else if (pos_load) begin
      sh_x   <= pos_x;
      sh_y   <= pos_y;
      sh_sel <= img_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_x         <= X0;
      act_y         <= Y0;
      frame_vld     <= 1'b0;
      row_base      <= '0;
      col_cnt       <= '0;
      s1_in_win     <= 1'b0;
      s1_addr       <= '0;
      in_window     <= 1'b0;
      video_address <= BLACK_ADDR;
    end else if (pix_en) begin
      if (frame_start) begin
        act_x     <= new_x;
        act_y     <= new_y;
        frame_vld <= 1'b1;
      end
      if (in_win) col_cnt <= col_eff + {10'd0, col_step};
      if (last_px) row_base <= row_step ? eff_row + ADDR_W'(IMG_W) : eff_row;
      else if (frame_start) row_base <= new_off;
      s1_in_win     <= in_win;
      s1_addr       <= eff_row + ADDR_W'(col_eff);
      in_window     <= s1_in_win;
      video_address <= s1_in_win ? s1_addr : BLACK_ADDR;
    end
  end

endmodule

// File: tb/tb_vga_window_addr_gen.sv
// Purpose: bench for vga_window_addr_gen; a default-parameter instance gets directed
// raster fragments, a small-image instance gets randomized full rasters.
// Expected values come from the closed-form address formula.
module tb_vga_window_addr_gen;

`ifdef VGA_SCALE2X_EN
  localparam int TS = 2;
`else
  localparam int TS = 1;
`endif
  localparam int AW = 250, AH = 250;
  localparam int BW = 7, BH = 5, BN = 3, BSTR = 256, HT = 24, VT = 16;
  localparam int X_END = 150 + AW * TS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  logic        a_en, a_ld, a_sel, a_inw;
  logic [9:0]  a_h, a_v, a_px, a_py;
  logic [31:0] a_addr;
  logic        b_en, b_ld, b_inw;
  logic [1:0]  b_sel;
  logic [9:0]  b_h, b_v, b_px, b_py;
  logic [15:0] b_addr;

  vga_window_addr_gen u_a (
    .clk(clk), .rst_n(rst_n), .pix_en(a_en), .hcnt(a_h), .vcnt(a_v),
    .img_sel(a_sel), .pos_x(a_px), .pos_y(a_py), .pos_load(a_ld),
    .video_address(a_addr), .in_window(a_inw)
  );

  vga_window_addr_gen #(
    .ADDR_W(16), .IMG_W(BW), .IMG_H(BH), .NUM_IMG(BN), .IMG_STRIDE(16'h100),
    .BLACK_ADDR(16'hFFFF), .X0(10'd4), .Y0(10'd2)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .pix_en(b_en), .hcnt(b_h), .vcnt(b_v),
    .img_sel(b_sel), .pos_x(b_px), .pos_y(b_py), .pos_load(b_ld),
    .video_address(b_addr), .in_window(b_inw)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic bit ref_in(input int h, input int v, input int x, input int y,
                                input int w, input int ht);
    return (h >= x) && (h < x + w * TS) && (v >= y) && (v < y + ht * TS);
  endfunction

  function automatic int ref_addr(input int h, input int v, input int x, input int y,
                                  input int w, input int sel, input int stride, input int nimg);
    int s;
    s = (sel >= nimg) ? 0 : sel;
    return s * stride + ((v - y) / TS) * w + (h - x) / TS;
  endfunction

  task automatic a_step(input int h, input int v, input bit en = 1'b1, input bit ld = 1'b0,
                        input int lx = 0, input int ly = 0, input int ls = 0);
    a_h = 10'(h); a_v = 10'(v); a_en = en; a_ld = ld;
    a_px = 10'(lx); a_py = 10'(ly); a_sel = 1'(ls);
    @(posedge clk); #1;
  endtask

  task automatic a_exp(input string tag, input int h, input int v, input int x, input int y,
                       input int sel);
    bit w;
    w = ref_in(h, v, x, y, AW, AH);
    check_val({tag, "_in"}, 32'(a_inw), 32'(w));
    check_val({tag, "_adr"}, a_addr, w ? 32'(ref_addr(h, v, x, y, AW, sel, 32'h10000, 2)) : 32'hFFFF);
  endtask

  // randomized-phase model state
  int  sh_x, sh_y, sh_s, ac_x, ac_y, ac_s, hc, vc;
  int  lx, ly, ls, nx, ny, ns, ex, ey, es, e_a, p1_a, p2_a;
  bit  vld, en, ld, fs, e_in, p1_in, p2_in;

  initial begin
    a_en = 0; a_ld = 0; a_h = 0; a_v = 0; a_px = 0; a_py = 0; a_sel = 0;
    b_en = 0; b_ld = 0; b_h = 0; b_v = 0; b_px = 0; b_py = 0; b_sel = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_a_adr", a_addr, 32'hFFFF);
    check_val("rst_a_in", 32'(a_inw), 32'd0);
    check_val("rst_b_adr", 32'(b_addr), 32'hFFFF);
    check_val("rst_b_in", 32'(b_inw), 32'd0);
    rst_n = 1'b1;

    // frame start with a coinciding load of image 1 at (150,80)
    a_step(0, 0, 1, 1, 150, 80, 1);
    a_step(150, 80);
    a_step(151, 80);
    a_exp("r22", 150, 80, 150, 80, 1);
    check_val("r22_lit", a_addr, 32'h10000);
    // mid-frame load of (0,0): current frame keeps the old window
    a_step(152, 80, 1, 1, 0, 0, 1);
    a_exp("px151", 151, 80, 150, 80, 1);
    a_step(10, 10);
    a_exp("px152", 152, 80, 150, 80, 1);
    a_step(153, 80);
    a_exp("r24_hold", 10, 10, 150, 80, 1);
    a_step(0, 0);
    a_exp("px153", 153, 80, 150, 80, 1);
    a_step(1, 0);
    a_exp("r24_new", 0, 0, 0, 0, 1);
    check_val("r24_lit", a_addr, 32'h10000);
    a_step(0, 0, 1, 1, 150, 80, 0);
    a_exp("r24_px", 1, 0, 0, 0, 1);

    // image 0 frame: only the last pixel of lines 80..328, then line 329 in full
    for (int v = 80; v <= 328; v++) a_step(X_END - 1, v);
    for (int h = 150; h <= X_END + 1; h++) begin
      a_step(h, 329);
      if (h == 151 || h == X_END || h == X_END + 1) a_exp("r23", h - 1, 329, 150, 80, 0);
    end

    // window clipped at hcnt=1023
    a_step(0, 0, 1, 1, 1000, 5, 1);
    for (int h = 1000; h <= 1023; h++) a_step(h, 5);
    a_step(1000, 6);
    a_exp("clip_last", 1023, 5, 1000, 5, 1);
    a_step(1001, 6);
    a_exp("clip_next", 1000, 6, 1000, 5, 1);
    for (int i = 0; i < 5; i++) begin
      a_step(1002 + i, 6, 1'b0);
      a_exp("freeze", 1000, 6, 1000, 5, 1);
    end
    a_step(1002, 6);
    a_exp("thaw", 1001, 6, 1000, 5, 1);
    a_step(1003, 6);

    // asynchronous reset mid-line, then black until the next frame start
    rst_n = 1'b0;
    #1;
    check_val("rst_async_adr", a_addr, 32'hFFFF);
    check_val("rst_async_in", 32'(a_inw), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    a_step(150, 80);
    a_step(151, 80);
    check_val("r19_adr", a_addr, 32'hFFFF);
    a_step(152, 80);
    check_val("r19_in", 32'(a_inw), 32'd0);
    a_step(0, 0);
    a_step(150, 80);
    a_step(151, 80);
    a_exp("r19_resume", 150, 80, 150, 80, 0);
    a_en = 1'b0;

    // randomized full rasters on the small instance
    sh_x = 4; sh_y = 2; sh_s = 0; ac_x = 4; ac_y = 2; ac_s = 0; vld = 0;
    hc = 0; vc = 0; p1_in = 0; p2_in = 0; p1_a = 'hFFFF; p2_a = 'hFFFF;
    for (int c = 0; c < 3000; c++) begin
      en = ($urandom_range(0, 3) != 0);
      ld = ($urandom_range(0, 19) == 0) || (hc == 0 && vc == 0 && $urandom_range(0, 1) == 1);
      lx = $urandom_range(0, HT - BW * TS);
      ly = $urandom_range(0, VT - BH * TS);
      ls = $urandom_range(0, 3);
      b_en = en; b_ld = ld; b_h = 10'(hc); b_v = 10'(vc);
      b_px = 10'(lx); b_py = 10'(ly); b_sel = 2'(ls);

      fs = en && hc == 0 && vc == 0;
      nx = ld ? lx : sh_x; ny = ld ? ly : sh_y; ns = ld ? ls : sh_s;
      ex = fs ? nx : ac_x; ey = fs ? ny : ac_y; es = fs ? ns : ac_s;
      e_in = (fs || vld) && ref_in(hc, vc, ex, ey, BW, BH);
      e_a = e_in ? (ref_addr(hc, vc, ex, ey, BW, es, BSTR, BN) & 'hFFFF) : 'hFFFF;

      @(posedge clk);
      if (en) begin
        p2_in = p1_in; p2_a = p1_a; p1_in = e_in; p1_a = e_a;
        if (fs) begin ac_x = nx; ac_y = ny; ac_s = ns; vld = 1; end
        hc++;
        if (hc == HT) begin hc = 0; vc = (vc + 1) % VT; end
      end
      if (ld) begin sh_x = lx; sh_y = ly; sh_s = ls; end
      #1;
      check_val("b_in", 32'(b_inw), 32'(p2_in));
      check_val("b_adr", 32'(b_addr), 32'(p2_a));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
